// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver sharing the bitperiod_i/locked_i baud interface
// with the transmit side. Emits one-cycle ticks for good bytes and framing errors.
// Optional: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around each
// sample point instead of a single sample.
module uart_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic        locked_i,
  input  logic [28:0] bitperiod_i,
  output logic        rx_done_tick_o,
  output logic [7:0]  dout_bo,
  output logic        rx_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RX_DATA,
    ST_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [31:0]            clk_counter_q, clk_counter_d;
  logic [2:0]             bit_counter_q, bit_counter_d;
  logic [7:0]             databuf_q, databuf_d;
  logic [7:0]             dout_q, dout_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic        rx_s;
  logic [31:0] full_period;
  logic [31:0] half_period;
  logic        sample_bit;
  logic        full_hit;
  logic        half_hit;
  logic [31:0] restart_val;

  assign rx_s        = sync_q[SYNC_STAGES-1];
  assign full_period = {3'h0, bitperiod_i};
  assign half_period = {4'h0, bitperiod_i[28:1]};

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] hist_q, hist_d;

  // Majority window: decision one clock late, counter restarts at 1 so the
  // bit grid keeps its period of bitperiod_i+1 clocks.
  always_comb begin
    hist_d      = {hist_q[1:0], rx_s};
    sample_bit  = (hist_d[0] & hist_d[1]) | (hist_d[1] & hist_d[2]) |
                  (hist_d[0] & hist_d[2]);
    full_hit    = (clk_counter_q == full_period + 32'd1);
    half_hit    = (clk_counter_q == half_period + 32'd1);
    restart_val = 32'd1;
  end

  // History of synchronized samples for the majority vote.
  always_ff @(posedge clk_i) begin
    if (rst_i) hist_q <= '1;
    else       hist_q <= hist_d;
  end
`else
  // Single sample of the synchronized line at the target count.
  always_comb begin
    sample_bit  = rx_s;
    full_hit    = (clk_counter_q == full_period);
    half_hit    = (clk_counter_q == half_period);
    restart_val = '0;
  end
`endif

  // Next-state and output logic of the receive FSM.
  always_comb begin
    state_d       = state_q;
    sync_d        = {sync_q[SYNC_STAGES-2:0], rx_i};
    rx_prev_d     = rx_s;
    clk_counter_d = clk_counter_q;
    bit_counter_d = bit_counter_q;
    databuf_d     = databuf_q;
    dout_d        = dout_q;
    done_d        = 1'b0;
    err_d         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s && locked_i) begin
          clk_counter_d = '0;
          state_d       = ST_START;
        end
      end
      ST_START: begin
        clk_counter_d = clk_counter_q + 32'd1;
        if (half_hit) begin
          if (!sample_bit) begin
            clk_counter_d = restart_val;
            bit_counter_d = '0;
            state_d       = ST_RX_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RX_DATA: begin
        clk_counter_d = clk_counter_q + 32'd1;
        if (full_hit) begin
          clk_counter_d = restart_val;
          databuf_d     = {sample_bit, databuf_q[7:1]};
          bit_counter_d = bit_counter_q + 3'd1;
          if (bit_counter_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        clk_counter_d = clk_counter_q + 32'd1;
        if (full_hit) begin
          if (sample_bit) begin
            dout_d = databuf_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loss of baud lock aborts any frame in progress silently.
    if (state_q != ST_IDLE && !locked_i) begin
      state_d = ST_IDLE;
      dout_d  = dout_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      sync_q        <= '1;
      rx_prev_q     <= 1'b1;
      clk_counter_q <= '0;
      bit_counter_q <= '0;
      databuf_q     <= '0;
      dout_q        <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      rx_prev_q     <= rx_prev_d;
      clk_counter_q <= clk_counter_d;
      bit_counter_q <= bit_counter_d;
      databuf_q     <= databuf_d;
      dout_q        <= dout_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign rx_done_tick_o = done_q;
  assign rx_err_o       = err_q;
  assign dout_bo        = dout_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written corner
// sequences; expected pulses are queued when the stop bit is driven and
// matched against DUT pulses by a negedge monitor.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        locked;
  logic [28:0] bitperiod;
  logic        rx_done;
  logic [7:0]  dout;
  logic        rx_err;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_i           (rx),
    .locked_i       (locked),
    .bitperiod_i    (bitperiod),
    .rx_done_tick_o (rx_done),
    .dout_bo        (dout),
    .rx_err_o       (rx_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [7:0]  dout;
    int unsigned cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rx_done === 1'b1 || rx_err === 1'b1) begin
      chk("tick_exclusive", {31'b0, rx_done & rx_err}, 32'd0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: done=%0b err=%0b dout=0x%0h expected no pulse at cycle %0d",
                 rx_done, rx_err, dout, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_kind_err", {31'b0, rx_err}, {31'b0, e.is_err});
        chk("pulse_dout", {24'b0, dout}, {24'b0, e.dout});
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // mode: 0 locked, 1 unlocked for the whole frame, 2 lock dropped at data bit 4
  // kind: 0 no pulse, 1 done tick, 2 framing error
  task automatic send_frame(input logic [7:0] data, input logic stop, input int nstop,
                            input int mode, input int kind, input logic [7:0] exp_dout);
    if (mode == 1) locked = 1'b0;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (mode == 2 && i == 4) locked = 1'b0;
      drive_bit(data[i], 16);
    end
    // Decision lands 11 clocks into the stop bit: mid-bit plus synchronizer delay.
    if (kind != 0) q.push_back('{is_err: (kind == 2), dout: exp_dout, cyc: cyc + 11});
    drive_bit(stop, 16 * nstop);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         nstop;
    int         mode;
    int         kind;
    logic [7:0] exp_dout;
    int         idle;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;

    tbl[0] = '{data: 8'hA5, stop: 1'b1, nstop: 1, mode: 0, kind: 1, exp_dout: 8'hA5, idle: 20};
    tbl[1] = '{data: 8'h00, stop: 1'b1, nstop: 2, mode: 0, kind: 1, exp_dout: 8'h00, idle: 0};
    tbl[2] = '{data: 8'hFF, stop: 1'b1, nstop: 2, mode: 0, kind: 1, exp_dout: 8'hFF, idle: 0};
    tbl[3] = '{data: 8'h3C, stop: 1'b1, nstop: 2, mode: 0, kind: 1, exp_dout: 8'h3C, idle: 20};
    tbl[4] = '{data: 8'h5A, stop: 1'b1, nstop: 1, mode: 0, kind: 1, exp_dout: 8'h5A, idle: 20};
    tbl[5] = '{data: 8'h81, stop: 1'b0, nstop: 1, mode: 0, kind: 2, exp_dout: 8'h5A, idle: 20};
    tbl[6] = '{data: 8'h33, stop: 1'b1, nstop: 1, mode: 1, kind: 0, exp_dout: 8'h5A, idle: 20};
    tbl[7] = '{data: 8'h33, stop: 1'b1, nstop: 1, mode: 2, kind: 0, exp_dout: 8'h5A, idle: 20};
    tbl[8] = '{data: 8'h33, stop: 1'b1, nstop: 1, mode: 0, kind: 1, exp_dout: 8'h33, idle: 20};

    rst       = 1'b1;
    rx        = 1'b1;
    locked    = 1'b1;
    bitperiod = 29'd15;
    repeat (3) @(negedge clk);
    chk("reset_dout", {24'b0, dout}, 32'h00);
    chk("reset_done", {31'b0, rx_done}, 32'd0);
    chk("reset_err", {31'b0, rx_err}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].nstop, tbl[i].mode, tbl[i].kind, tbl[i].exp_dout);
      rx = 1'b1;
      repeat (tbl[i].idle) @(negedge clk);
      chk($sformatf("frame%0d_pending", i), q.size(), 32'd0);
      chk($sformatf("frame%0d_dout", i), {24'b0, dout}, {24'b0, tbl[i].exp_dout});
      locked = 1'b1;
    end

    // Short low glitch on an idle line: false start, then a real frame.
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 40);
    chk("glitch_pending", q.size(), 32'd0);
    chk("glitch_dout", {24'b0, dout}, 32'h33);
    send_frame(8'h42, 1'b1, 1, 0, 1, 8'h42);
    drive_bit(1'b1, 20);
    chk("after_glitch_pending", q.size(), 32'd0);
    chk("after_glitch_dout", {24'b0, dout}, 32'h42);

    // Reset in the middle of data bit 3, then a complete frame.
    b = 8'hC3;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) drive_bit(b[i], 16);
    drive_bit(b[3], 8);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_dout", {24'b0, dout}, 32'h00);
    chk("midreset_done", {31'b0, rx_done}, 32'd0);
    chk("midreset_err", {31'b0, rx_err}, 32'd0);
    drive_bit(1'b1, 40);
    chk("midreset_pending", q.size(), 32'd0);
    chk("midreset_idle_dout", {24'b0, dout}, 32'h00);
    send_frame(b, 1'b1, 1, 0, 1, 8'hC3);
    drive_bit(1'b1, 20);
    chk("after_reset_pending", q.size(), 32'd0);
    chk("after_reset_dout", {24'b0, dout}, 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
